escalonador_chamadas: RTL and testbench

//  Request scheduler and trip sequencer for the elevator manager. Captures (origem, destino)

---
 rtl/elevador_pkg.sv | 29 ++
 rtl/fila_requisicoes.sv | 61 ++++++
 rtl/escalonador_chamadas.sv | 128 ++++++++++++
 tb/tb_escalonador_chamadas.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator manager: floor width, defaults, FSM state codes and the
// call record stored in the request FIFO.
package elevador_pkg;

  localparam int unsigned FLOOR_W          = 4;
  localparam int unsigned N_ANDARES_PADRAO = 16;
  localparam int unsigned T_PORTA_PADRAO   = 50;

  typedef enum logic [2:0] {
    StOcioso       = 3'd0,
    StBusca        = 3'd1,
    StVaiOrigem    = 3'd2,
    StPortaOrigem  = 3'd3,
    StVaiDestino   = 3'd4,
    StPortaDestino = 3'd5
  } estado_e;

  typedef struct packed {
    logic [FLOOR_W-1:0] origem;
    logic [FLOOR_W-1:0] destino;
  } chamada_t;

  // Floor fields are wider than needed when the building has fewer than 2**FLOOR_W floors.
  function automatic logic andar_valido(input logic [FLOOR_W-1:0] andar,
                                        input int unsigned n_andares);
    return 32'(andar) < n_andares;
  endfunction

endpackage

// File: rtl/fila_requisicoes.sv
// Synchronous FIFO of (origem, destino) calls with circular pointers and an occupancy count.
module fila_requisicoes
  import elevador_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  chamada_t din,
  output chamada_t dout,
  output logic     vazia,
  output logic     cheia
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CntMax = (PtrW + 1)'(Depth);

  chamada_t        mem_q [Depth];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign vazia   = (cnt_q == '0);
  assign cheia   = (cnt_q == CntMax);
  assign do_push = push & ~cheia;
  assign do_pop  = pop & ~vazia;
  assign dout    = mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PtrW'(1);
    if (do_pop)  rd_d = rd_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count guards every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/escalonador_chamadas.sv
// Call scheduler and trip sequencer: queues (origem, destino) calls and drives the car to the
// pickup floor, opens the door, drives to the drop-off floor and opens the door again.
module escalonador_chamadas
  import elevador_pkg::*;
#(
  parameter int unsigned N_ANDARES    = N_ANDARES_PADRAO,
  parameter int unsigned PROFUNDIDADE = 4,
  parameter int unsigned T_PORTA      = T_PORTA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               novaEntrada,
  input  logic [FLOOR_W-1:0] origem,
  input  logic [FLOOR_W-1:0] destino,
  input  logic [FLOOR_W-1:0] andarAtual,
  output logic               subir,
  output logic               descer,
  output logic               abrirPorta,
  output logic [FLOOR_W-1:0] andarAlvo,
  output logic               ocupado,
  output logic               filaVazia,
  output logic               filaCheia,
  output logic               chamadaDescartada,
  output logic [2:0]         dbEstado
);

  localparam int unsigned         TimerW     = (T_PORTA > 1) ? $clog2(T_PORTA) : 1;
  localparam logic [TimerW-1:0]   TimerCarga = TimerW'(T_PORTA - 1);

  estado_e            estado_q, estado_d;
  logic               nova_q;
  logic               desc_q, desc_d;
  logic [FLOOR_W-1:0] alvo_q, alvo_d;
  logic [FLOOR_W-1:0] reg_destino_q, reg_destino_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  chamada_t           cabeca, nova_chamada;
  logic               pulso, invalida, push, pop;

  assign pulso = novaEntrada & ~nova_q;
  // Full is the registered flag, so a push while full is dropped even if BUSCA pops now.
  assign invalida = (origem == destino) | ~andar_valido(origem, N_ANDARES)
                  | ~andar_valido(destino, N_ANDARES) | filaCheia;
  assign push         = pulso & ~invalida;
  assign desc_d       = pulso & invalida;
  assign pop          = (estado_q == StBusca);
  assign nova_chamada = {origem, destino};

  fila_requisicoes #(
    .Depth (PROFUNDIDADE)
  ) u_fila (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (nova_chamada),
    .dout  (cabeca),
    .vazia (filaVazia),
    .cheia (filaCheia)
  );

  always_comb begin
    estado_d      = estado_q;
    alvo_d        = alvo_q;
    reg_destino_d = reg_destino_q;
    timer_d       = timer_q;
    subir         = 1'b0;
    descer        = 1'b0;
    abrirPorta    = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (iniciar && !filaVazia) estado_d = StBusca;
      end
      StBusca: begin
        alvo_d        = cabeca.origem;
        reg_destino_d = cabeca.destino;
        estado_d      = StVaiOrigem;
      end
      StVaiOrigem, StVaiDestino: begin
        subir  = (andarAtual < alvo_q);
        descer = (andarAtual > alvo_q);
        if (andarAtual == alvo_q) begin
          timer_d  = TimerCarga;
          estado_d = (estado_q == StVaiOrigem) ? StPortaOrigem : StPortaDestino;
        end
      end
      StPortaOrigem, StPortaDestino: begin
        abrirPorta = 1'b1;
        timer_d    = timer_q - TimerW'(1);
        if (timer_q == '0) begin
          if (estado_q == StPortaOrigem) begin
            alvo_d   = reg_destino_q;
            estado_d = StVaiDestino;
          end else if (iniciar && !filaVazia) begin
            estado_d = StBusca;
          end else begin
            estado_d = StOcioso;
          end
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clock) begin
    // Tracks the input through reset so a strobe held across reset is not seen as a new call.
    nova_q <= novaEntrada;
    if (reset) begin
      estado_q      <= StOcioso;
      desc_q        <= 1'b0;
      alvo_q        <= '0;
      reg_destino_q <= '0;
      timer_q       <= '0;
    end else begin
      estado_q      <= estado_d;
      desc_q        <= desc_d;
      alvo_q        <= alvo_d;
      reg_destino_q <= reg_destino_d;
      timer_q       <= timer_d;
    end
  end

  assign andarAlvo         = alvo_q;
  assign ocupado           = (estado_q != StOcioso);
  assign chamadaDescartada = desc_q;
  assign dbEstado          = estado_q;

endmodule

// File: tb/tb_escalonador_chamadas.sv
// Bench for escalonador_chamadas: a car model answers subir/descer, and a scoreboard of expected
// door stops is filled as calls are issued and drained as the door opens.
module tb_escalonador_chamadas;
  import elevador_pkg::*;

  localparam int unsigned NA   = 8;
  localparam int unsigned PROF = 4;
  localparam int unsigned TP   = 50;
  localparam logic [13:0] RESET_VEC = {3'b000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};

  logic       clock = 1'b0;
  logic       reset, iniciar, novaEntrada;
  logic [3:0] origem, destino;
  logic [3:0] andarAtual = '0;
  logic       subir, descer, abrirPorta, ocupado, filaVazia, filaCheia, chamadaDescartada;
  logic [3:0] andarAlvo;
  logic [2:0] dbEstado;

  int   n_ok = 0, n_tot = 0;
  int   exp_paradas[$];
  int   exp_desc = 0, obs_desc = 0, viol = 0, porta_cnt = 0;
  logic porta_ant = 1'b0;

  always #5 clock = ~clock;

  escalonador_chamadas #(
    .N_ANDARES    (NA),
    .PROFUNDIDADE (PROF),
    .T_PORTA      (TP)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .iniciar           (iniciar),
    .novaEntrada       (novaEntrada),
    .origem            (origem),
    .destino           (destino),
    .andarAtual        (andarAtual),
    .subir             (subir),
    .descer            (descer),
    .abrirPorta        (abrirPorta),
    .andarAlvo         (andarAlvo),
    .ocupado           (ocupado),
    .filaVazia         (filaVazia),
    .filaCheia         (filaCheia),
    .chamadaDescartada (chamadaDescartada),
    .dbEstado          (dbEstado)
  );

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_tot++;
    if (obs === esp) n_ok++;
    else $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, esp);
  endtask

  function automatic logic [13:0] saidas();
    return {subir, descer, abrirPorta, andarAlvo, ocupado, filaVazia, filaCheia,
            chamadaDescartada, dbEstado};
  endfunction

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic chamar(input int o, input int d, input bit aceita);
    origem      = 4'(o);
    destino     = 4'(d);
    novaEntrada = 1'b1;
    ciclo();
    novaEntrada = 1'b0;
    if (aceita) begin
      exp_paradas.push_back(o);
      exp_paradas.push_back(d);
    end else begin
      exp_desc++;
    end
    ciclo();
  endtask

  task automatic esperar_estado(input logic [2:0] e, input int limite, input string tag);
    int k = 0;
    while (dbEstado !== e && k < limite) begin
      ciclo();
      k++;
    end
    verificar(tag, dbEstado, e);
  endtask

  // Monitor and car model: sample on the falling edge, then move the car one floor.
  always @(negedge clock) begin
    if (abrirPorta && !porta_ant) begin
      if (exp_paradas.size() == 0) verificar("parada_extra", 1, 0);
      else verificar("andar_parada", andarAtual, exp_paradas.pop_front());
      porta_cnt = 0;
    end
    if (abrirPorta) porta_cnt++;
    if (!abrirPorta && porta_ant) verificar("tempo_porta", porta_cnt, TP);
    porta_ant = abrirPorta;
    if (chamadaDescartada) obs_desc++;
    if (subir && descer) viol++;
    if ((subir || descer) && !(dbEstado == 3'd2 || dbEstado == 3'd4)) viol++;
    if (abrirPorta && !(dbEstado == 3'd3 || dbEstado == 3'd5)) viol++;
    if (subir && andarAtual < 4'(NA - 1)) andarAtual = andarAtual + 4'd1;
    else if (descer && andarAtual > 4'd0) andarAtual = andarAtual - 4'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulacao excedeu o tempo limite");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with the call strobe held high
    reset = 1'b1; iniciar = 1'b1; novaEntrada = 1'b1; origem = 4'd1; destino = 4'd2;
    repeat (3) ciclo();
    verificar("reset_saidas", saidas(), RESET_VEC);
    reset = 1'b0;
    repeat (3) ciclo();
    verificar("sem_push_pos_reset", filaVazia, 1);
    verificar("ocioso_pos_reset", dbEstado, 0);
    novaEntrada = 1'b0;
    ciclo();

    // Single trip (1,4) from floor 0
    chamar(1, 4, 1);
    verificar("lat_busca", dbEstado, 1);
    ciclo();
    verificar("lat_vai_origem", dbEstado, 2);
    verificar("subir_origem", {subir, descer}, 2'b10);
    esperar_estado(3'd0, 600, "fim_viagem_1");
    verificar("fila_vazia_1", filaVazia, 1);
    verificar("andar_final_1", andarAtual, 4);

    // Invalid calls
    chamar(2, 2, 0);
    chamar(1, 9, 0);
    chamar(8, 0, 0);
    verificar("descartes_invalidos", obs_desc, exp_desc);
    verificar("fila_vazia_invalidos", filaVazia, 1);
    verificar("ocioso_invalidos", dbEstado, 0);

    // Fill the FIFO with dispatch disabled, overflow once, then serve in order
    iniciar = 1'b0;
    chamar(0, 1, 1);
    chamar(2, 3, 1);
    chamar(4, 5, 1);
    verificar("nao_cheia_3", filaCheia, 0);
    chamar(7, 6, 1);
    verificar("cheia_apos_4", filaCheia, 1);
    chamar(1, 0, 0);
    verificar("descarte_cheia", obs_desc, exp_desc);
    verificar("ocioso_sem_iniciar", dbEstado, 0);
    iniciar = 1'b1;
    ciclo();
    verificar("busca_apos_iniciar", dbEstado, 1);
    esperar_estado(3'd0, 3000, "fim_fila_cheia");
    verificar("fila_vazia_4", filaVazia, 1);

    // Car already at origem
    chamar(6, 3, 1);
    verificar("busca_5", dbEstado, 1);
    ciclo();
    verificar("vai_origem_parado", {dbEstado, subir, descer}, {3'd2, 2'b00});
    ciclo();
    verificar("porta_imediata", {dbEstado, abrirPorta}, {3'd3, 1'b1});
    esperar_estado(3'd4, 200, "vai_destino_5");
    verificar("descer_destino", {subir, descer}, 2'b01);
    esperar_estado(3'd0, 400, "fim_viagem_5");
    verificar("andar_final_5", andarAtual, 3);
    verificar("paradas_pendentes", exp_paradas.size(), 0);

    // Reset mid-trip with two calls queued
    chamar(0, 7, 1);
    chamar(1, 2, 1);
    chamar(3, 4, 1);
    esperar_estado(3'd4, 400, "chega_vai_destino_6");
    verificar("duas_na_fila", {filaVazia, filaCheia}, 2'b00);
    reset = 1'b1;
    ciclo();
    verificar("reset_meio_viagem", saidas(), RESET_VEC);
    reset = 1'b0;
    exp_paradas.delete();
    ciclo();
    verificar("ocioso_apos_reset", {dbEstado, filaVazia}, {3'd0, 1'b1});

    verificar("sem_violacoes", viol, 0);
    $display("%0d/%0d checks passed", n_ok, n_tot);
    $finish;
  end

endmodule
